// File: rtl/afifo_pkg.sv
// afifo_pkg: word width shared with the async FIFO and write-arbiter state encoding
package afifo_pkg;
    localparam int F_WIDTH = 8;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BURST = 1'b1;
    typedef enum logic {IDLE = ST_IDLE, BURST = ST_BURST} state_t;
endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// afifo_wr_arbiter_if: producer request bundle plus FIFO write port seen by the write arbiter
interface afifo_wr_arbiter_if
    import afifo_pkg::*;
#(
    parameter int f_width = F_WIDTH,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ*f_width-1:0] src_data;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] gnt;
    logic f_full_flag;
    logic f_almost_full_flag;
    logic w_en;
    logic [f_width-1:0] d_in;
    modport master(input req, src_data, f_full_flag, f_almost_full_flag, output ack, gnt, w_en, d_in);
    modport slave(output req, src_data, f_full_flag, f_almost_full_flag, input ack, gnt, w_en, d_in);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first requester strictly after rr_ptr, searching upward with wrap-around
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);
    logic [IW-1:0] c;

    assign found = |req;

    // walk from the farthest candidate back to the nearest so the nearest hit wins
    always_comb begin
        idx = '0;
        c = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            c = IW'((int'(rr_ptr) + k) % N_REQ);
            if (req[c]) idx = c;
        end
    end
endmodule

// File: rtl/afifo_wr_arbiter.sv
// afifo_wr_arbiter: round-robin, burst-bounded sharing of the afifo write port.
// Optional AFIFO_WARB_ALMOST_FULL_THROTTLE_EN: withhold new grants while the FIFO is almost full.
module afifo_wr_arbiter
    import afifo_pkg::*;
#(
    parameter int f_width = F_WIDTH,
    parameter int N_REQ = 4,
    parameter int BURST_LEN = 4
) (
    input logic w_clk,
    input logic reset,
    afifo_wr_arbiter_if.master bus
);
    localparam int IW = $clog2(N_REQ);

    state_t state, state_n;
    logic [N_REQ-1:0] gnt, gnt_n;
    logic [7:0] burst_cnt, cnt_n;
    logic [IW-1:0] rr_ptr, ptr_n, owner, idx;
    logic [f_width-1:0] d;
    logic found, owner_req, wen, grant_ok;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req(bus.req),
        .rr_ptr(rr_ptr),
        .found(found),
        .idx(idx)
    );

    // owner index and its data slice, both derived from the one-hot grant (zero when idle)
    always_comb begin
        owner = '0;
        d = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) begin
                owner = IW'(i);
                d = d | bus.src_data[i*f_width +: f_width];
            end
    end

    assign owner_req = |(bus.req & gnt);
    assign wen = owner_req & ~bus.f_full_flag;
    assign bus.w_en = wen;
    assign bus.ack = wen ? gnt : '0;
    assign bus.d_in = d;
    assign bus.gnt = gnt;

`ifdef AFIFO_WARB_ALMOST_FULL_THROTTLE_EN
    assign grant_ok = found & ~bus.f_full_flag & ~bus.f_almost_full_flag;
`else
    logic unused_af;
    assign grant_ok = found & ~bus.f_full_flag;
    assign unused_af = bus.f_almost_full_flag;
`endif

    // arbitrate in IDLE; in BURST release on dropped request or last word, otherwise count writes
    always_comb begin
        state_n = state;
        gnt_n = gnt;
        cnt_n = burst_cnt;
        ptr_n = rr_ptr;
        if (state == IDLE) begin
            if (grant_ok) begin
                state_n = BURST;
                gnt_n = N_REQ'(1) << idx;
                cnt_n = '0;
            end
        end else if (!owner_req || (wen && burst_cnt == 8'(BURST_LEN - 1))) begin
            state_n = IDLE;
            gnt_n = '0;
            ptr_n = owner;
        end else if (wen) begin
            cnt_n = burst_cnt + 8'd1;
        end
    end

    // state register; rr_ptr resets to the last producer so producer 0 is served first
    always_ff @(posedge w_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt <= '0;
            burst_cnt <= '0;
            rr_ptr <= IW'(N_REQ - 1);
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            burst_cnt <= cnt_n;
            rr_ptr <= ptr_n;
        end
    end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// tb_afifo_wr_arbiter: directed scenarios with producer models and an expected-write scoreboard
module tb_afifo_wr_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    afifo_wr_arbiter_if #(.f_width(8), .N_REQ(4)) bus();
    afifo_wr_arbiter #(.f_width(8), .N_REQ(4), .BURST_LEN(4)) dut (
        .w_clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] pw [4][8];
    int pn [4];
    int pp [4];
    logic [11:0] q [$];
    logic [3:0] acked;
    logic [9:0] wpat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int i, input int n);
        for (int k = 0; k < n; k++) pw[i][pn[i]+k] = 8'(i * 16 + pn[i] + k + 1);
        pn[i] += n;
    endtask

    task automatic expect_w(input int i, input int a, input int b);
        for (int j = a; j <= b; j++) q.push_back({4'(1 << i), pw[i][j]});
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.req[i] = pp[i] < pn[i];
            bus.src_data[i*8 +: 8] = 8'h00;
            if (pp[i] < pn[i]) bus.src_data[i*8 +: 8] = pw[i][pp[i]];
        end
    endtask

    task automatic sample();
        logic [11:0] e;
        drive();
        #1;
        chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
        chk("ack_in_gnt", 32'(bus.ack & ~bus.gnt), 0);
        if (bus.gnt == 4'b0) chk("d_in_idle", 32'(bus.d_in), 0);
        if (bus.w_en) begin
            if (q.size() == 0) chk("write_without_expect", 32'(bus.w_en), 0);
            else begin
                e = q.pop_front();
                chk("wr_ack", 32'(bus.ack), 32'(e[11:8]));
                chk("wr_data", 32'(bus.d_in), 32'(e[7:0]));
            end
        end else chk("ack_without_wen", 32'(bus.ack), 0);
    endtask

    task automatic step();
        acked = bus.ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acked[i]) pp[i]++;
    endtask

    task automatic cyc();
        sample();
        step();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            cyc();
            n++;
        end
        chk("drain_empty", q.size(), 0);
        repeat (3) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.f_full_flag = 1'b0;
        bus.f_almost_full_flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pn[i] = 0;
            pp[i] = 0;
        end
        drive();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.f_full_flag = 1'b0;
        bus.f_almost_full_flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pn[i] = 0;
            pp[i] = 0;
        end
        drive();
        @(posedge clk);
        #1;
        chk("reset_gnt", 32'(bus.gnt), 0);
        chk("reset_wen", 32'(bus.w_en), 0);
        chk("reset_ack", 32'(bus.ack), 0);
        chk("reset_d_in", 32'(bus.d_in), 0);

        do_reset();
        add(0, 6);
        expect_w(0, 0, 5);
        wpat = '0;
        for (int c = 0; c < 10; c++) begin
            sample();
            wpat = {wpat[8:0], bus.w_en};
            step();
            if (c == 0) chk("single_first_gnt", 32'(bus.gnt), 32'h1);
        end
        chk("single_wen_pattern", 32'(wpat), 32'(10'b0111101100));
        chk("single_release_gnt", 32'(bus.gnt), 0);
        chk("single_sb_empty", q.size(), 0);

        do_reset();
        add(0, 8);
        add(1, 4);
        add(2, 4);
        add(3, 4);
        expect_w(0, 0, 3);
        expect_w(1, 0, 3);
        expect_w(2, 0, 3);
        expect_w(3, 0, 3);
        expect_w(0, 4, 7);
        cyc();
        chk("all_first_gnt", 32'(bus.gnt), 32'h1);
        drain(80);

        do_reset();
        add(0, 5);
        expect_w(0, 0, 4);
        cyc();
        chk("stall_gnt", 32'(bus.gnt), 32'h1);
        cyc();
        cyc();
        bus.f_full_flag = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("stall_wen", 32'(bus.w_en), 0);
            chk("stall_gnt_held", 32'(bus.gnt), 32'h1);
            chk("stall_ack", 32'(bus.ack), 0);
            step();
        end
        bus.f_full_flag = 1'b0;
        sample();
        chk("stall_word3", 32'(bus.w_en), 1);
        step();
        sample();
        chk("stall_word4", 32'(bus.w_en), 1);
        step();
        sample();
        chk("stall_burst_end", 32'(bus.gnt), 0);
        step();
        drain(40);

        do_reset();
        add(2, 1);
        add(3, 2);
        expect_w(2, 0, 0);
        expect_w(3, 0, 1);
        cyc();
        chk("early_gnt2", 32'(bus.gnt), 32'h4);
        cyc();
        sample();
        chk("early_drop_wen", 32'(bus.w_en), 0);
        step();
        chk("early_release", 32'(bus.gnt), 0);
        add(0, 1);
        add(1, 1);
        add(2, 2);
        expect_w(0, 0, 0);
        expect_w(1, 0, 0);
        expect_w(2, 1, 2);
        cyc();
        chk("early_next_gnt3", 32'(bus.gnt), 32'h8);
        drain(60);

        do_reset();
        add(1, 4);
        expect_w(1, 0, 1);
        cyc();
        chk("mid_gnt1", 32'(bus.gnt), 32'h2);
        cyc();
        cyc();
        drive();
        #1;
        chk("mid_pre_wen", 32'(bus.w_en), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 0);
        chk("mid_rst_wen", 32'(bus.w_en), 0);
        chk("mid_rst_ack", 32'(bus.ack), 0);
        step();
        reset = 1'b0;
        add(0, 2);
        expect_w(0, 0, 1);
        expect_w(1, 2, 3);
        cyc();
        chk("mid_after_gnt0", 32'(bus.gnt), 32'h1);
        drain(60);

        do_reset();
        bus.f_almost_full_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            add(i, 1);
            expect_w(i, 0, 0);
        end
        cyc();
`ifdef AFIFO_WARB_ALMOST_FULL_THROTTLE_EN
        chk("af_gnt", 32'(bus.gnt), 0);
`else
        chk("af_gnt", 32'(bus.gnt), 32'h1);
`endif
        bus.f_almost_full_flag = 1'b0;
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
- Write-side arbiter that shares the single write port of the async FIFO (`afifo`) among N_REQ producers in the `w_clk` domain.
- Round-robin grant with bounded bursts, so no single producer monopolises the FIFO.
- Drives `w_en`/`d_in` of the FIFO.
- Observes `f_full_flag` and `f_almost_full_flag` to throttle writes.

Parameters:
- `f_width`, 8, data word width; must match the FIFO.
- `N_REQ`, 4, number of producers (2..16).
- `BURST_LEN`, 4, maximum words written per grant (1..255).

Ports:
- `w_clk` input 1: write-domain clock. One clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input N_REQ: `req[i]`=1 means producer i has a valid word on its data slice.
- `src_data` input N_REQ*f_width: producer i data at `[i*f_width +: f_width]`.
- `ack` output N_REQ: one-hot; `ack[i]`=1 means producer i's word is written this cycle.
- `gnt` output N_REQ: registered one-hot current owner; all zero when idle.
- `f_full_flag` input 1: FIFO full, synchronised to `w_clk`.
- `f_almost_full_flag` input 1: FIFO almost full, `w_clk` domain.
- `w_en` output 1: FIFO write enable.
- `d_in` output f_width: FIFO write data.

Behaviour:
- Reset values:
  - State=IDLE, `gnt`=0, `burst_cnt`=0.
  - `rr_ptr`=N_REQ-1, so producer 0 has first priority.
  - Hence `w_en`=0, `ack`=0, `d_in`=0 (muxed from `gnt`=0).
  - Reset asserted mid-burst aborts immediately. No partial handshake survives; the in-flight word is not written.
- States: IDLE, BURST.
- IDLE:
  - If `|req` and !`f_full_flag`, select the first i with `req[i]`=1, searching (`rr_ptr`+1) mod N_REQ upward with wrap.
  - Register `gnt`<=onehot(i), `burst_cnt`<=0, go to BURST. This costs a 1-cycle arbitration bubble.
  - Otherwise stay in IDLE with `gnt`=0.
- BURST, combinational outputs, with `owner` = index of `gnt`:
  - `w_en` = `req[owner]` & !`f_full_flag`.
  - `ack[owner]` = `w_en`; all other `ack` bits = 0.
  - `d_in` = `src_data` slice of `owner`; `d_in` = 0 when `gnt`=0.
- BURST, per cycle:
  - If `w_en`: increment `burst_cnt`.
    - If `burst_cnt`==BURST_LEN-1, release: `gnt`<=0, `rr_ptr`<=owner, go to IDLE.
  - If !`req[owner]`: release immediately, even with `burst_cnt`=0. Same updates: `rr_ptr`<=owner, IDLE.
  - If `req[owner]` & `f_full_flag`: stall. Hold `gnt` and `burst_cnt`; `w_en`=0. A full stall does not count toward the burst.
- Consequences:
  - Max throughput per grant: BURST_LEN words in BURST_LEN consecutive cycles, then 1 idle cycle.
  - Fairness: after releasing owner k, producer k has lowest priority at the next arbitration.
  - `f_full_flag` asserted and released at the same edge: the combinational `w_en` reflects the current-cycle flag only.
  - Producer contract: `src_data` and `req` are held stable until `ack`. A producer dropping `req` without `ack` loses nothing, because no write occurs.
- `gnt` is always one-hot or zero. `ack` is never asserted outside `gnt`.
- `f_almost_full_flag` is ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: `AFIFO_WARB_ALMOST_FULL_THROTTLE_EN`.
- Defined:
  - IDLE issues no new grant while `f_almost_full_flag`=1.
  - An ongoing burst continues until its normal end or `f_full_flag`.
  - Leaves headroom for the burst in progress.
- Undefined: the IDLE grant condition is only !`f_full_flag`; `f_almost_full_flag` is unused.

Decomposition:
- Shared package `afifo_pkg`:
  - state encoding localparams ST_IDLE=1'b0, ST_BURST=1'b1.
  - default widths `f_width`/`f_depth` shared with `afifo`.
- One natural sub-module: `rr_pick`.
  - Combinational round-robin next-index finder.
  - Inputs: `req`, `rr_ptr`. Outputs: `found`, `idx`.
  - Reusable for the planned read-side scheduler.

Test Plan:
- Single producer: `req`=4'b0001, data 8'h01..8'h06, no full.
  - `gnt`=0001 one cycle after reset release.
  - Writes 01..04 on 4 consecutive cycles, 1 bubble, then 05,06.
  - Release when `req` drops.
- All requesting, `req`=4'b1111: grant order 0,1,2,3,0.
  - Each burst is exactly 4 words (`w_en` pulses).
  - `ack` is one-hot and matches `gnt` every write cycle.
- Full stall: `f_full_flag`=1 for 3 cycles after word 2 of a burst.
  - `w_en`=0, `gnt` held, no `ack`.
  - On release, words 3 and 4 are written; the burst totals 4.
- Early release: owner 2 drops `req` after 1 word while producer 3 requests.
  - Next grant goes to 3; `rr_ptr`=2.
  - Producer 2 re-requesting waits behind 3, 0 and 1.
- Reset mid-burst: assert `reset` asynchronously after 2 words.
  - `gnt`=0 and `w_en`=0 immediately.
  - After release, producer 0 wins first.
- With `AFIFO_WARB_ALMOST_FULL_THROTTLE_EN`: `f_almost_full_flag`=1 with `req`=1111 in IDLE gives no grant. Without the macro, the grant is issued the next cycle.
